cpu_step_ctrl: RTL and testbench

//   Board-level execution controller for the pipelined CPU core.
//   - Turns a raw push-button and a run switch into a single-cycle clock enable (cpu_en).
//   - cpu_en gates the PC, all pipeline registers, the register file and data-memory writes.
//   - Sequences the core in single-step or free-run mode at a human-visible rate.
//   - Reports progress (step_count) for the 7-segment display mux.

---
 rtl/cpu_step_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// Execution controller for the pipelined core: debounced single-step, timed free-run and
// optional PC breakpoint (enabled by defining CPU_STEP_BP_EN), producing a one-cycle cpu_en.
`timescale 1ns/1ps

module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int STEP_PERIOD     = 50000000,
    parameter int PC_W            = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            btn_step,
    input  logic            sw_run,
    input  logic [PC_W-1:0] pc,
`ifdef CPU_STEP_BP_EN
    input  logic [PC_W-1:0] bp_addr,
`endif
    output logic            cpu_en,
    output logic [1:0]      state,
    output logic [15:0]     step_count,
    output logic            halted
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PER_W = $clog2(STEP_PERIOD + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(STEP_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_STEP = 2'b01,
        S_RUN  = 2'b10,
        S_HALT = 2'b11
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_btn_meta;
    logic               r_btn_sync;
    logic               r_run_meta;
    logic               r_run_sync;
    logic [DEB_W-1:0]   r_deb_cnt;
    logic               r_btn_stable;
    logic               r_btn_stable_d;
    logic [PER_W-1:0]   r_per_cnt;
    logic [PER_W-1:0]   w_per_cnt_nxt;
    logic [15:0]        r_step_count;
    logic               w_step_req;
    logic               w_terminal;
    logic               w_bp_hit;
    logic               w_cpu_en;

    // Two-flop synchronizers for the asynchronous button and switch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
            r_run_meta <= 1'b0;
            r_run_sync <= 1'b0;
        end else begin
            r_btn_meta <= btn_step;
            r_btn_sync <= r_btn_meta;
            r_run_meta <= sw_run;
            r_run_sync <= r_run_meta;
        end
    end

    // Accept a new button level only after it differs from the stable level for DEBOUNCE_CYCLES.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_deb_cnt      <= {DEB_W{1'b0}};
            r_btn_stable   <= 1'b0;
            r_btn_stable_d <= 1'b0;
        end else begin
            r_btn_stable_d <= r_btn_stable;
            if (r_btn_sync == r_btn_stable) begin
                r_deb_cnt <= {DEB_W{1'b0}};
            end else if (r_deb_cnt == DEB_LAST) begin
                r_deb_cnt    <= {DEB_W{1'b0}};
                r_btn_stable <= r_btn_sync;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
        end
    end

    assign w_step_req = r_btn_stable & ~r_btn_stable_d;
    assign w_terminal = (r_state == S_RUN) && (r_per_cnt == PER_LAST);

`ifdef CPU_STEP_BP_EN
    assign w_bp_hit = (pc == bp_addr);
`else
    logic w_pc_unused;
    assign w_pc_unused = ^pc;
    assign w_bp_hit    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; dropping run_s always wins over a pending step or breakpoint.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_run_sync) begin
                    w_state_nxt = S_RUN;
                end else if (w_step_req) begin
                    w_state_nxt = S_STEP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_STEP: begin
                w_state_nxt = S_IDLE;
            end
            S_RUN: begin
                if (!r_run_sync) begin
                    w_state_nxt = S_IDLE;
                end else if (w_terminal && w_bp_hit) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_HALT: begin
                if (!r_run_sync) begin
                    w_state_nxt = S_IDLE;
                end else if (w_step_req) begin
                    w_state_nxt = S_STEP;
                end else begin
                    w_state_nxt = S_HALT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic: enable pulse and the next period count.
    always_comb begin
        w_cpu_en      = 1'b0;
        w_per_cnt_nxt = {PER_W{1'b0}};
        case (r_state)
            S_STEP: begin
                w_cpu_en = 1'b1;
            end
            S_RUN: begin
                if (r_run_sync && w_terminal) begin
                    w_cpu_en = ~w_bp_hit;
                end else if (r_run_sync) begin
                    w_per_cnt_nxt = r_per_cnt + PER_W'(1);
                end else begin
                    w_per_cnt_nxt = {PER_W{1'b0}};
                end
            end
            default: begin
                w_cpu_en      = 1'b0;
                w_per_cnt_nxt = {PER_W{1'b0}};
            end
        endcase
    end

    // Period counter and wrapping pulse counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_per_cnt    <= {PER_W{1'b0}};
            r_step_count <= 16'h0000;
        end else begin
            r_per_cnt <= w_per_cnt_nxt;
            if (w_cpu_en) begin
                r_step_count <= r_step_count + 16'h0001;
            end else begin
                r_step_count <= r_step_count;
            end
        end
    end

    assign cpu_en     = w_cpu_en;
    assign state      = r_state;
    assign step_count = r_step_count;
`ifdef CPU_STEP_BP_EN
    assign halted     = (r_state == S_HALT);
`else
    assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl with short debounce/period; a second instance with
// STEP_PERIOD=1 exercises the step_count wrap.
`timescale 1ns/1ps

module tb_cpu_step_ctrl;

    localparam int D    = 4;
    localparam int P    = 3;
    localparam int PC_W = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_step;
    logic        sw_run;
    logic [31:0] pc_m;
    logic [31:0] bp_addr;
    logic        cpu_en;
    logic [1:0]  state;
    logic [15:0] step_count;
    logic        halted;

    logic        f_reset;
    logic        f_sw_run;
    logic        f_btn;
    logic [31:0] f_pc;
    logic [31:0] f_bp;
    logic        f_cpu_en;
    logic [1:0]  f_state;
    logic [15:0] f_step_count;
    logic        f_halted;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses[$];
    int f_pulses = 0;
    logic prev_en = 1'b0;

    always #5 clk = ~clk;

    cpu_step_ctrl #(.DEBOUNCE_CYCLES(D), .STEP_PERIOD(P), .PC_W(PC_W)) u_dut (
        .clk(clk), .reset(reset), .btn_step(btn_step), .sw_run(sw_run), .pc(pc_m),
`ifdef CPU_STEP_BP_EN
        .bp_addr(bp_addr),
`endif
        .cpu_en(cpu_en), .state(state), .step_count(step_count), .halted(halted)
    );

    cpu_step_ctrl #(.DEBOUNCE_CYCLES(D), .STEP_PERIOD(1), .PC_W(PC_W)) u_dut_fast (
        .clk(clk), .reset(f_reset), .btn_step(f_btn), .sw_run(f_sw_run), .pc(f_pc),
`ifdef CPU_STEP_BP_EN
        .bp_addr(f_bp),
`endif
        .cpu_en(f_cpu_en), .state(f_state), .step_count(f_step_count), .halted(f_halted)
    );

    // Core model: PC advances by 4 on every enable.
    always @(posedge clk or posedge reset) begin
        if (reset) pc_m <= 32'h0;
        else if (cpu_en) pc_m <= pc_m + 32'h4;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse recorder, sampled on the falling edge.
    always @(negedge clk) begin
        if (cpu_en === 1'b1) begin
            pulses.push_back(cyc);
            checks++;
            if (prev_en === 1'b1) begin
                errors++;
                $display("FAIL en_isolated: cpu_en high at cycles %0d and %0d, required single-cycle", cyc - 1, cyc);
            end
        end
        prev_en = cpu_en;
        if (f_cpu_en === 1'b1) f_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; f_reset = 1'b1;
        btn_step = 1'b0; sw_run = 1'b0; bp_addr = 32'h0;
        f_btn = 1'b0; f_sw_run = 1'b0; f_pc = 32'h0; f_bp = 32'hFFFF_FFFF;
        ticks(3);
        checks += 4;
        if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en: got %b want 0", cpu_en); end
        if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", state); end
        if (step_count !== 16'h0) begin errors++; $display("FAIL reset_step_count: got %h want 0000", step_count); end
        if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        reset = 1'b0; f_reset = 1'b0;
        tick();
    endtask

    task automatic test_bounce();
        int t0;
        pulses.delete();
        btn_step = 1'b1; tick(); btn_step = 1'b0; tick();
        btn_step = 1'b1; tick(); btn_step = 1'b0; tick();
        btn_step = 1'b1; t0 = cyc;
        ticks(12);
        btn_step = 1'b0;
        ticks(12);
        checks += 3;
        if (pulses.size() != 1) begin
            errors++; $display("FAIL bounce_pulses: got %0d want 1", pulses.size());
        end else begin
            checks++;
            if (pulses[0] - t0 < D + 2 || pulses[0] - t0 > D + 4) begin
                errors++; $display("FAIL bounce_latency: got %0d want %0d+/-1", pulses[0] - t0, D + 3);
            end
        end
        if (step_count !== 16'd1) begin errors++; $display("FAIL bounce_step_count: got %0d want 1", step_count); end
        if (state !== 2'b00) begin errors++; $display("FAIL bounce_state: got %b want 00", state); end
    endtask

    // Random bouncy presses: one pulse each, D+3 after the start of the final high run.
    task automatic test_press_random();
        for (int it = 0; it < 6; it++) begin
            logic lv[$];
            int base, hs, expt;
            logic [15:0] sc0;
            lv.delete();
            for (int b = 0; b < int'($urandom_range(0, 3)); b++) lv.push_back(1'($urandom_range(0, 1)));
            hs = lv.size();
            for (int h = 0; h < int'($urandom_range(8, 14)); h++) lv.push_back(1'b1);
            for (int b = 0; b < int'($urandom_range(0, 3)); b++) lv.push_back(1'($urandom_range(0, 1)));
            for (int z = 0; z < 10; z++) lv.push_back(1'b0);
            while (hs > 0 && lv[hs - 1] == 1'b1) hs--;
            sc0 = step_count;
            pulses.delete();
            base = cyc;
            expt = base + hs + D + 3;
            foreach (lv[i]) begin
                btn_step = lv[i];
                tick();
            end
            checks += 2;
            if (pulses.size() != 1) begin
                errors++; $display("FAIL press_rand_pulses[%0d]: got %0d want 1", it, pulses.size());
            end else begin
                checks++;
                if (pulses[0] < expt - 1 || pulses[0] > expt + 1) begin
                    errors++; $display("FAIL press_rand_latency[%0d]: got cycle %0d want %0d+/-1", it, pulses[0], expt);
                end
            end
            if (step_count !== sc0 + 16'd1) begin
                errors++; $display("FAIL press_rand_count[%0d]: got %0d want %0d", it, step_count, sc0 + 16'd1);
            end
        end
    endtask

    // Run windows of L cycles yield floor((L-1)/P) pulses spaced P apart.
    task automatic test_run();
        for (int it = 0; it < 5; it++) begin
            int len, k, nexp;
            len = (it == 0) ? 40 : int'($urandom_range(4, 30));
            nexp = (len - 1) / P;
            pulses.delete();
            k = cyc;
            sw_run = 1'b1;
            ticks(4);
            checks++;
            if (state !== 2'b10) begin errors++; $display("FAIL run_state[%0d]: got %b want 10", it, state); end
            ticks(len - 4);
            sw_run = 1'b0;
            ticks(3);
            checks++;
            if (state !== 2'b00) begin errors++; $display("FAIL run_stop_state[%0d]: got %b want 00", it, state); end
            ticks(P + 3);
            checks++;
            if (pulses.size() != nexp) begin
                errors++; $display("FAIL run_pulses[%0d]: L=%0d got %0d want %0d", it, len, pulses.size(), nexp);
            end
            for (int i = 1; i < pulses.size(); i++) begin
                checks++;
                if (pulses[i] - pulses[i - 1] != P) begin
                    errors++; $display("FAIL run_spacing[%0d]: got %0d want %0d", it, pulses[i] - pulses[i - 1], P);
                end
            end
        end
    endtask

    task automatic test_step_in_run();
        logic saw_step;
        logic [15:0] sc0;
        int nexp;
        saw_step = 1'b0;
        sc0 = step_count;
        nexp = (20 - 1) / P;
        pulses.delete();
        btn_step = 1'b1; sw_run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state === 2'b01) saw_step = 1'b1;
        end
        sw_run = 1'b0; btn_step = 1'b0;
        ticks(12);
        checks += 3;
        if (saw_step !== 1'b0) begin errors++; $display("FAIL step_in_run_state: got STEP seen want none"); end
        if (pulses.size() != nexp) begin errors++; $display("FAIL step_in_run_pulses: got %0d want %0d", pulses.size(), nexp); end
        if (step_count !== sc0 + 16'(nexp)) begin
            errors++; $display("FAIL step_in_run_count: got %0d want %0d", step_count, sc0 + 16'(nexp));
        end
    endtask

    task automatic test_breakpoint();
        int n;
        do_reset();
`ifdef CPU_STEP_BP_EN
        bp_addr = 32'h0000_000C;
        sw_run = 1'b1;
        n = 0;
        while (halted !== 1'b1 && n < 40) begin tick(); n++; end
        checks += 4;
        if (halted !== 1'b1) begin errors++; $display("FAIL bp_halt: got halted=%b want 1", halted); end
        if (state !== 2'b11) begin errors++; $display("FAIL bp_state: got %b want 11", state); end
        if (step_count !== 16'd3) begin errors++; $display("FAIL bp_step_count: got %0d want 3", step_count); end
        if (pc_m !== 32'hC) begin errors++; $display("FAIL bp_pc: got %h want 0000000c", pc_m); end
        pulses.delete();
        btn_step = 1'b1;
        n = 0;
        while (state !== 2'b10 && n < 30) begin tick(); n++; end
        checks += 4;
        if (state !== 2'b10) begin errors++; $display("FAIL bp_resume_state: got %b want 10", state); end
        if (pulses.size() != 1) begin errors++; $display("FAIL bp_step_pulses: got %0d want 1", pulses.size()); end
        if (pc_m !== 32'h10) begin errors++; $display("FAIL bp_step_pc: got %h want 00000010", pc_m); end
        if (step_count !== 16'd4) begin errors++; $display("FAIL bp_step_count2: got %0d want 4", step_count); end
        ticks(P + 2);
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL bp_past: got halted=%b want 0", halted); end
        btn_step = 1'b0; sw_run = 1'b0;
        ticks(12);
`else
        n = 0;
        sw_run = 1'b1;
        ticks(20);
        checks += 2;
        if (halted !== 1'b0) begin errors++; $display("FAIL nobp_halted: got %b want 0", halted); end
        if (state !== 2'b10) begin errors++; $display("FAIL nobp_state: got %b want 10", state); end
        sw_run = 1'b0;
        ticks(5 + n);
`endif
    endtask

    task automatic test_midreset();
        int k, n;
        sw_run = 1'b1;
        pulses.delete();
        n = 0;
        while (pulses.size() == 0 && n < 20) begin tick(); n++; end
        checks++;
        if (pulses.size() == 0) begin errors++; $display("FAIL midreset_prep: got 0 pulses want >0"); end
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks += 3;
        if (cpu_en !== 1'b0) begin errors++; $display("FAIL midreset_cpu_en: got %b want 0", cpu_en); end
        if (step_count !== 16'h0) begin errors++; $display("FAIL midreset_step_count: got %h want 0000", step_count); end
        if (state !== 2'b00) begin errors++; $display("FAIL midreset_state: got %b want 00", state); end
        ticks(2);
        reset = 1'b0;
        k = cyc;
        pulses.delete();
        ticks(10);
        checks++;
        if (pulses.size() == 0) begin
            errors++; $display("FAIL midreset_first: got no pulse want one");
        end else if (pulses[0] - k < 5 || pulses[0] - k > 6) begin
            errors++; $display("FAIL midreset_first: got %0d cycles want 5..6", pulses[0] - k);
        end
        sw_run = 1'b0;
        ticks(5);
    endtask

    task automatic test_wrap();
        f_pulses = 0;
        f_sw_run = 1'b1;
        ticks(40000);
        checks++;
        if (f_step_count !== 16'(f_pulses)) begin
            errors++; $display("FAIL wrap_mid: got %0d want %0d", f_step_count, 16'(f_pulses));
        end
        ticks(65537 - 40000);
        f_sw_run = 1'b0;
        ticks(5);
        checks += 2;
        if (f_pulses != 65536) begin errors++; $display("FAIL wrap_pulses: got %0d want 65536", f_pulses); end
        if (f_step_count !== 16'h0000) begin errors++; $display("FAIL wrap_count: got %h want 0000", f_step_count); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_press_random();
        test_run();
        test_step_in_run();
        test_breakpoint();
        test_midreset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
